// File: rtl/tap_controller_if.sv
// TAP pin/strobe bundle: TMS toward the controller, scan-chain strobes back out.
// Master drives TMS and observes the strobes; slave is the TAP controller.
interface tap_controller_if;
    logic tms;
    logic reset;
    logic tdo_en;
    logic shiftIR;
    logic captureIR;
    logic clockIR;
    logic updateIR;
    logic shiftDR;
    logic captureDR;
    logic clockDR;
    logic updateDR;
    logic select;

    modport master (
        output tms,
        input  reset, tdo_en, shiftIR, captureIR, clockIR, updateIR,
        input  shiftDR, captureDR, clockDR, updateDR, select
    );

    modport slave (
        input  tms,
        output reset, tdo_en, shiftIR, captureIR, clockIR, updateIR,
        output shiftDR, captureDR, clockDR, updateDR, select
    );
endinterface

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller: 16-state Moore FSM stepped by TMS on rising tck.
// Strobes are registered from the next state, so they are glitch-free and track the state entered.
//
// state | meaning
// TLR   | Test-Logic-Reset, downstream reset asserted
// RTI   | Run-Test/Idle
// SELDR | Select-DR-Scan
// CAPDR | Capture-DR
// SHDR  | Shift-DR
// EX1DR | Exit1-DR
// PAUDR | Pause-DR
// EX2DR | Exit2-DR
// UPDDR | Update-DR
// SELIR | Select-IR-Scan
// CAPIR | Capture-IR
// SHIR  | Shift-IR
// EX1IR | Exit1-IR
// PAUIR | Pause-IR
// EX2IR | Exit2-IR
// UPDIR | Update-IR
module tap_controller (
    input  logic             tck,
    input  logic             trst,
    tap_controller_if.slave  tap
);
    typedef enum logic [3:0] {
        TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PAUDR, EX2DR,
        UPDDR, SELIR, CAPIR, SHIR, EX1IR, PAUIR, EX2IR, UPDIR
    } state_t;

    // Strobe vector bit positions
    localparam int B_RESET  = 10;
    localparam int B_TDOEN  = 9;
    localparam int B_SHIR   = 8;
    localparam int B_CAPIR  = 7;
    localparam int B_CLKIR  = 6;
    localparam int B_UPDIR  = 5;
    localparam int B_SHDR   = 4;
    localparam int B_CAPDR  = 3;
    localparam int B_CLKDR  = 2;
    localparam int B_UPDDR  = 1;
    localparam int B_SELECT = 0;

    localparam logic [10:0] OUT_TLR = 11'b100_0000_0000;

    state_t      r_state;
    state_t      w_next;
    logic [10:0] r_out;
    logic [10:0] w_out;

    always_ff @(posedge tck) begin
        if (trst) begin
            r_state <= TLR;
            r_out   <= OUT_TLR;
        end else begin
            r_state <= w_next;
            r_out   <= w_out;
        end
    end

    always_comb begin
        w_next = r_state;
        w_out  = '0;
        case (r_state)
            TLR:     w_next = tap.tms ? TLR   : RTI;
            RTI:     w_next = tap.tms ? SELDR : RTI;
            SELDR:   w_next = tap.tms ? SELIR : CAPDR;
            CAPDR:   w_next = tap.tms ? EX1DR : SHDR;
            SHDR:    w_next = tap.tms ? EX1DR : SHDR;
            EX1DR:   w_next = tap.tms ? UPDDR : PAUDR;
            PAUDR:   w_next = tap.tms ? EX2DR : PAUDR;
            EX2DR:   w_next = tap.tms ? UPDDR : SHDR;
            UPDDR:   w_next = tap.tms ? SELDR : RTI;
            SELIR:   w_next = tap.tms ? TLR   : CAPIR;
            CAPIR:   w_next = tap.tms ? EX1IR : SHIR;
            SHIR:    w_next = tap.tms ? EX1IR : SHIR;
            EX1IR:   w_next = tap.tms ? UPDIR : PAUIR;
            PAUIR:   w_next = tap.tms ? EX2IR : PAUIR;
            EX2IR:   w_next = tap.tms ? UPDIR : SHIR;
            UPDIR:   w_next = tap.tms ? SELDR : RTI;
            default: w_next = TLR;
        endcase

        // Decode of the state about to be entered; registered above.
        case (w_next)
            TLR:   w_out[B_RESET] = 1'b1;
            CAPDR: begin
                w_out[B_CAPDR] = 1'b1;
                w_out[B_CLKDR] = 1'b1;
            end
            SHDR: begin
                w_out[B_SHDR]  = 1'b1;
                w_out[B_CLKDR] = 1'b1;
                w_out[B_TDOEN] = 1'b1;
            end
            UPDDR: w_out[B_UPDDR] = 1'b1;
            SELIR, EX1IR, PAUIR, EX2IR: w_out[B_SELECT] = 1'b1;
            CAPIR: begin
                w_out[B_CAPIR]  = 1'b1;
                w_out[B_CLKIR]  = 1'b1;
                w_out[B_SELECT] = 1'b1;
            end
            SHIR: begin
                w_out[B_SHIR]   = 1'b1;
                w_out[B_CLKIR]  = 1'b1;
                w_out[B_TDOEN]  = 1'b1;
                w_out[B_SELECT] = 1'b1;
            end
            UPDIR: begin
                w_out[B_UPDIR]  = 1'b1;
                w_out[B_SELECT] = 1'b1;
            end
            default: w_out = '0;
        endcase
    end

    assign tap.reset     = r_out[B_RESET];
    assign tap.tdo_en    = r_out[B_TDOEN];
    assign tap.shiftIR   = r_out[B_SHIR];
    assign tap.captureIR = r_out[B_CAPIR];
    assign tap.clockIR   = r_out[B_CLKIR];
    assign tap.updateIR  = r_out[B_UPDIR];
    assign tap.shiftDR   = r_out[B_SHDR];
    assign tap.captureDR = r_out[B_CAPDR];
    assign tap.clockDR   = r_out[B_CLKDR];
    assign tap.updateDR  = r_out[B_UPDDR];
    assign tap.select    = r_out[B_SELECT];
endmodule

// File: tb/tb_tap_controller.sv
// Scoreboard bench for tap_controller: directed TMS/TRST vectors push the expected
// strobe pattern of the state each step should enter; a monitor pops and compares.
module tb_tap_controller;
    logic tck  = 1'b0;
    logic trst = 1'b0;

    tap_controller_if tap_if ();

    tap_controller dut (
        .tck  (tck),
        .trst (trst),
        .tap  (tap_if.slave)
    );

    always #5 tck = ~tck;

    localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5,
                   PAUDR = 6, EX2DR = 7, UPDDR = 8, SELIR = 9, CAPIR = 10,
                   SHIR = 11, EX1IR = 12, PAUIR = 13, EX2IR = 14, UPDIR = 15;

    string names [16] = '{"TLR", "RTI", "SelDR", "CapDR", "ShDR", "Ex1DR", "PauDR",
                          "Ex2DR", "UpdDR", "SelIR", "CapIR", "ShIR", "Ex1IR",
                          "PauIR", "Ex2IR", "UpdIR"};

    typedef struct {
        logic [10:0] exp;
        int          st;
        int          step;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_steps  = 0;
    int   q[$];

    logic [10:0] obs;
    assign obs = {tap_if.reset, tap_if.tdo_en, tap_if.shiftIR, tap_if.captureIR,
                  tap_if.clockIR, tap_if.updateIR, tap_if.shiftDR, tap_if.captureDR,
                  tap_if.clockDR, tap_if.updateDR, tap_if.select};

    // {reset,tdo_en,shiftIR,captureIR,clockIR,updateIR,shiftDR,captureDR,clockDR,updateDR,select}
    function automatic logic [10:0] exp_out(input int s);
        case (s)
            TLR:   return 11'b10000000000;
            CAPDR: return 11'b00000001100;
            SHDR:  return 11'b01000010100;
            UPDDR: return 11'b00000000010;
            SELIR: return 11'b00000000001;
            CAPIR: return 11'b00011000001;
            SHIR:  return 11'b01101000001;
            EX1IR: return 11'b00000000001;
            PAUIR: return 11'b00000000001;
            EX2IR: return 11'b00000000001;
            UPDIR: return 11'b00000100001;
            default: return 11'b00000000000;
        endcase
    endfunction

    task automatic step(input logic t_tms, input logic t_trst, input int st);
        exp_t e;
        @(negedge tck);
        tap_if.tms = t_tms;
        trst       = t_trst;
        n_steps++;
        e.exp  = exp_out(st);
        e.st   = st;
        e.step = n_steps;
        sb.push_back(e);
    endtask

    task automatic run_seq(input string s, input int ex[$]);
        for (int i = 0; i < s.len(); i++)
            step(s[i] == 8'h31, 1'b0, ex[i]);
    endtask

    initial begin
        forever begin
            @(posedge tck);
            #1;
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                n_checks++;
                if (obs === mon_e.exp)
                    n_pass++;
                else
                    $display("FAIL step%0d %s: outputs got %b want %b",
                             mon_e.step, names[mon_e.st], obs, mon_e.exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        int run_st[$];
        int run_n[$];
        tap_if.tms = 1'b0;

        // trst reset, then trst again mid-ShDR and with tms=1
        step(1'b0, 1'b1, TLR);
        step(1'b0, 1'b0, RTI);
        step(1'b1, 1'b0, SELDR);
        step(1'b0, 1'b0, CAPDR);
        step(1'b0, 1'b0, SHDR);
        step(1'b0, 1'b0, SHDR);
        step(1'b0, 1'b1, TLR);
        step(1'b1, 1'b1, TLR);
        step(1'b1, 1'b0, TLR);

        // reset by five TMS=1 from ShDR
        q = '{RTI, SELDR, CAPDR, SHDR};
        run_seq("0100", q);
        q = '{EX1DR, UPDDR, SELDR, SELIR, TLR};
        run_seq("11111", q);

        // IR scan, pause and resume
        q = '{RTI, SELDR, SELIR, CAPIR, SHIR, SHIR, EX1IR};
        run_seq("0110001", q);
        q = '{PAUIR, PAUIR, PAUIR, PAUIR, EX2IR, SHIR, SHIR, SHIR, SHIR, EX1IR, UPDIR, RTI};
        run_seq("000010000110", q);

        // DR scan from RTI
        q = '{SELDR, CAPDR, SHDR, SHDR, SHDR, EX1DR, UPDDR, RTI};
        run_seq("10000110", q);

        // full walk through all states after trst
        step(1'b0, 1'b1, TLR);
        run_st = '{TLR, RTI, SELDR, SELIR, CAPIR, SHIR, EX1IR, PAUIR, EX2IR, SHIR, EX1IR,
                   UPDIR, RTI, SELDR, CAPDR, SHDR, EX1DR, PAUDR, EX2DR, SHDR, EX1DR,
                   UPDDR, RTI, SELDR, SELIR, TLR};
        run_n  = '{9, 1, 1, 1, 1, 2, 1, 4, 1, 4, 1, 1, 3, 1, 1, 3, 1, 4, 1, 4, 1, 1, 3,
                   1, 1, 5};
        q = {};
        foreach (run_st[i])
            for (int k = 0; k < run_n[i]; k++)
                q.push_back(run_st[i]);
        run_seq("111111111011000100001000011000100001000010000110001111111", q);

        repeat (3) @(posedge tck);
        #2;
        n_checks++;
        if (sb.size() == 0)
            n_pass++;
        else
            $display("FAIL drain: pending expectations got %0d want 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/tap_controller.md
# tap_controller

IEEE 1149.1 Test Access Port controller: a 16-state Moore FSM clocked by the test clock and steered by TMS. It generates the capture/shift/update/clock strobes for the instruction register and data registers, the IR/DR TDO-mux select, the TDO output enable, and a reset for downstream test logic. It sits between the JTAG pins and the IR/DR scan chains in the drop-in JTAG block.

## Interface
- No parameters.
- tck  in  1  test clock; all state changes on rising edge
- trst  in  1  synchronous, active-high reset; forces Test-Logic-Reset on the next rising tck
- tms  in  1  test mode select; sampled on rising tck
- reset  out  1  high while in Test-Logic-Reset; resets downstream IR/DR logic
- tdo_en  out  1  TDO output enable; high in Shift-IR or Shift-DR
- shiftIR  out  1  high in Shift-IR
- captureIR  out  1  high in Capture-IR
- clockIR  out  1  IR clock enable; high in Capture-IR or Shift-IR
- updateIR  out  1  high in Update-IR
- shiftDR  out  1  high in Shift-DR
- captureDR  out  1  high in Capture-DR
- clockDR  out  1  DR clock enable; high in Capture-DR or Shift-DR
- updateDR  out  1  high in Update-DR
- select  out  1  TDO mux select; 1 = IR path (Select-IR-Scan through Update-IR), 0 otherwise

## Operation
- States: TLR, RTI, SelDR, CapDR, ShDR, Ex1DR, PauDR, Ex2DR, UpdDR, SelIR, CapIR, ShIR, Ex1IR, PauIR, Ex2IR, UpdIR. Encoding is free; a 4-bit binary code is sufficient.
- Transitions (tms=0 / tms=1):
  - TLR→RTI/TLR; RTI→RTI/SelDR
  - SelDR→CapDR/SelIR; CapDR→ShDR/Ex1DR; ShDR→ShDR/Ex1DR; Ex1DR→PauDR/UpdDR; PauDR→PauDR/Ex2DR; Ex2DR→ShDR/UpdDR; UpdDR→RTI/SelDR
  - SelIR→CapIR/TLR; CapIR→ShIR/Ex1IR; ShIR→ShIR/Ex1IR; Ex1IR→PauIR/UpdIR; PauIR→PauIR/Ex2IR; Ex2IR→ShIR/UpdIR; UpdIR→RTI/SelDR
- Five consecutive tms=1 cycles reach TLR from any state.
- trst=1 overrides tms: next state is TLR.
- All outputs are pure Moore decodes of the current state and change only after a rising tck. No glitches are permitted: outputs are either registered from next-state or decoded from the state register.
- In TLR: reset=1, select=0, all other outputs 0.
- Exactly one of captureIR/shiftIR/updateIR/captureDR/shiftDR/updateDR is high at any time, or none.

## Timing
- State register updates on rising tck. tms must be stable around that edge; the bench drives tms on falling tck.
- Latency: an output reflects the new state in the same cycle the state is entered, i.e. it is valid one rising edge after the tms that caused the transition is sampled.
- After trst is asserted: TLR on the next rising edge, with reset=1 from that edge.
- Power-up before the first reset: undefined. trst, or 5 cycles of tms=1, establishes TLR.
- Pause and Shift states hold indefinitely with tms=0. RTI holds with tms=0. TLR holds with tms=1.

## Test plan
- Reset: trst=1 for one rising edge with tms=0 -> state TLR, reset=1, every other output 0. Repeat mid-ShDR -> TLR next edge.
- Reset by TMS: from ShDR, drive tms=1 for 5 cycles -> passes Ex1DR, UpdDR (updateDR=1 for one cycle), SelDR, SelIR, TLR.
- IR scan: from TLR, tms=0,1,1,0,0,0,1 -> RTI, SelDR, SelIR (select=1), CapIR (captureIR=clockIR=1), then ShIR for 2 cycles (shiftIR=clockIR=tdo_en=1), then Ex1IR.
- IR pause/resume: continue tms=0,0,0,0,1,0,0,0,0,1,1,0 -> PauIR x4, Ex2IR, ShIR x4, Ex1IR, UpdIR (updateIR=1 exactly one cycle), RTI with select=0.
- DR scan: from RTI, tms=1,0,0,0,0,1,1,0 -> SelDR, CapDR (captureDR=clockDR=1, select=0), ShDR x3 (tdo_en=1), Ex1DR, UpdDR (updateDR=1), RTI.
- Full sequence 111111111011000100001000011000100001000010000110001111111 applied MSB first, one bit per cycle, after trst -> every state visited per the transitions above, ending in TLR with reset=1.
